// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared constants, state encoding and sizing helper for the HUB75 scan controller
// Contents:
//   DEF_COLS / DEF_ROWS / DEF_PLANES / DEF_DELAY_BASE : default geometry and plane-0 show time
//   hub75_state_t                                     : scan FSM state encoding
//   show_cnt_width()                                  : width needed for the longest SHOW period
package hub75_pkg;

    localparam int DEF_COLS       = 64;
    localparam int DEF_ROWS       = 16;
    localparam int DEF_PLANES     = 8;
    localparam int DEF_DELAY_BASE = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_BLANK    = 3'd3,
        ST_LATCH    = 3'd4,
        ST_SHOW     = 3'd5,
        ST_DONE     = 3'd6
    } hub75_state_t;

    // Longest SHOW period is the last plane under binary-coded modulation.
    function automatic int show_cnt_width(input int base, input int planes);
        return $clog2((base << (planes - 1)) + 1);
    endfunction

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// rtl/hub75_scan_ctrl_if.sv - plane-start handshake and panel drive bundle of the HUB75 scan controller
// Signals:
//   in_HUB75_INIT  : start-plane pulse from the plane cache
//   out_COL        : column address to the plane cache
//   out_ROW        : panel row address A..D
//   out_PLANE      : current bit-plane index
//   out_SHIFT_CLK  : panel CLK
//   out_LATCH      : panel LAT
//   out_OE_N       : panel OE, active low
//   out_PLANE_DONE : one-cycle pulse when the plane has been displayed
//   out_BUSY       : high whenever the controller is not idle
// Modports: ctrl (scan controller side), panel (cache/panel side)
interface hub75_scan_ctrl_if
    import hub75_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int PLANES = DEF_PLANES
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int PL_W  = $clog2(PLANES);

    logic             in_HUB75_INIT;
    logic [COL_W-1:0] out_COL;
    logic [ROW_W-1:0] out_ROW;
    logic [PL_W-1:0]  out_PLANE;
    logic             out_SHIFT_CLK;
    logic             out_LATCH;
    logic             out_OE_N;
    logic             out_PLANE_DONE;
    logic             out_BUSY;

    modport ctrl (
        input  in_HUB75_INIT,
        output out_COL, out_ROW, out_PLANE, out_SHIFT_CLK, out_LATCH,
               out_OE_N, out_PLANE_DONE, out_BUSY
    );

    modport panel (
        output in_HUB75_INIT,
        input  out_COL, out_ROW, out_PLANE, out_SHIFT_CLK, out_LATCH,
               out_OE_N, out_PLANE_DONE, out_BUSY
    );

endinterface

// File: rtl/hub75_show_timer.sv
// rtl/hub75_show_timer.sv - down-counter timing the OE-low SHOW period of one row
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset
//   i_load     : load i_load_val (asserted in the cycle before SHOW)
//   i_load_val : SHOW length in cycles (>= 1)
//   i_count    : decrement while in SHOW
//   o_done     : high in the last SHOW cycle
module hub75_show_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_count,
    output logic             o_done
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // The counter holds the number of SHOW cycles still to go including the current one.
    assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// rtl/hub75_scan_ctrl.sv - HUB75 LED panel row-scan controller for one bit-plane per start pulse
// Shifts COLS columns per row, blanks, latches, then shows the row for T_show cycles;
// after ROWS rows it pulses out_PLANE_DONE and advances the plane index.
// Optional macro HUB75_BCM_EN: T_show = DELAY_BASE << plane (binary-coded modulation);
// otherwise T_show = DELAY_BASE for every plane.
// Ports:
//   clk : clock, all logic on posedge
//   rst : synchronous active-high reset
//   bus : hub75_scan_ctrl_if.ctrl (start pulse in, panel drive and status out)
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int COLS       = DEF_COLS,
    parameter int ROWS       = DEF_ROWS,
    parameter int PLANES     = DEF_PLANES,
    parameter int DELAY_BASE = DEF_DELAY_BASE
) (
    input  logic               clk,
    input  logic               rst,
    hub75_scan_ctrl_if.ctrl    bus
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int PL_W  = $clog2(PLANES);
    localparam int CNT_W = show_cnt_width(DELAY_BASE, PLANES);

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [PL_W-1:0]  PLANE_LAST = PL_W'(PLANES - 1);

    hub75_state_t     r_state, w_next_state;
    logic [COL_W-1:0] r_col, w_next_col;
    logic [ROW_W-1:0] r_row, w_next_row;
    logic [ROW_W-1:0] r_out_row, w_next_out_row;
    logic [PL_W-1:0]  r_plane, w_next_plane;
    logic             r_sclk, r_latch, r_oe_n, r_done, r_busy;
    logic             w_load, w_count, w_timer_done;
    logic [CNT_W-1:0] w_t_show;

`ifdef HUB75_BCM_EN
    assign w_t_show = CNT_W'(DELAY_BASE) << r_plane;
`else
    assign w_t_show = CNT_W'(DELAY_BASE);
`endif

    hub75_show_timer #(.CNT_W(CNT_W)) u_show_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_t_show),
        .i_count    (w_count),
        .o_done     (w_timer_done)
    );

    always_comb begin
        w_next_state   = r_state;
        w_next_col     = r_col;
        w_next_row     = r_row;
        w_next_out_row = r_out_row;
        w_next_plane   = r_plane;
        w_load         = 1'b0;
        w_count        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_HUB75_INIT) begin
                    w_next_state = ST_SHIFT_LO;
                    w_next_col   = '0;
                    w_next_row   = '0;
                end
            end
            ST_SHIFT_LO: w_next_state = ST_SHIFT_HI;
            ST_SHIFT_HI: begin
                if (r_col == COL_LAST) begin
                    w_next_state   = ST_BLANK;
                    // Row address changes only while the panel is blanked.
                    w_next_out_row = r_row;
                end else begin
                    w_next_state = ST_SHIFT_LO;
                    w_next_col   = r_col + 1'b1;
                end
            end
            ST_BLANK: w_next_state = ST_LATCH;
            ST_LATCH: begin
                w_next_state = ST_SHOW;
                w_load       = 1'b1;
            end
            ST_SHOW: begin
                w_count = 1'b1;
                if (w_timer_done) begin
                    if (r_row == ROW_LAST) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_SHIFT_LO;
                        w_next_row   = r_row + 1'b1;
                        w_next_col   = '0;
                    end
                end
            end
            ST_DONE: begin
                // The start pulse is deliberately not looked at here.
                w_next_state = ST_IDLE;
                w_next_plane = (r_plane == PLANE_LAST) ? '0 : r_plane + 1'b1;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each flop lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_out_row <= '0;
            r_plane   <= '0;
            r_sclk    <= 1'b0;
            r_latch   <= 1'b0;
            r_oe_n    <= 1'b1;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_col     <= w_next_col;
            r_row     <= w_next_row;
            r_out_row <= w_next_out_row;
            r_plane   <= w_next_plane;
            r_sclk    <= (w_next_state == ST_SHIFT_HI);
            r_latch   <= (w_next_state == ST_LATCH);
            r_oe_n    <= (w_next_state != ST_SHOW);
            r_done    <= (w_next_state == ST_DONE);
            r_busy    <= (w_next_state != ST_IDLE);
        end
    end

    assign bus.out_COL        = r_col;
    assign bus.out_ROW        = r_out_row;
    assign bus.out_PLANE      = r_plane;
    assign bus.out_SHIFT_CLK  = r_sclk;
    assign bus.out_LATCH      = r_latch;
    assign bus.out_OE_N       = r_oe_n;
    assign bus.out_PLANE_DONE = r_done;
    assign bus.out_BUSY       = r_busy;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb/tb_hub75_scan_ctrl.sv - scoreboard testbench for hub75_scan_ctrl
module tb_hub75_scan_ctrl;

    localparam int COLS       = 4;
    localparam int ROWS       = 2;
    localparam int PLANES     = 4;
    localparam int DELAY_BASE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hub75_scan_ctrl_if #(.COLS(COLS), .ROWS(ROWS), .PLANES(PLANES)) bus ();

    hub75_scan_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .PLANES(PLANES), .DELAY_BASE(DELAY_BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum int {EV_SHIFT = 0, EV_LATCH = 1, EV_SHOW = 2, EV_DONE = 3} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       a;
        int       b;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks    = 0;
    int  n_fail      = 0;
    int  cyc         = 0;
    int  model_plane = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int t_show(input int p);
`ifdef HUB75_BCM_EN
        return DELAY_BASE << p;
`else
        return DELAY_BASE;
`endif
    endfunction

    function automatic int plane_len(input int p);
        return ROWS * (2 * COLS + 2 + t_show(p));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected panel activity for one plane whose start pulse is sampled on posedge s.
    task automatic push_plane(input int p, input int s);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) exp_q.push_back('{EV_SHIFT, c, 0});
            exp_q.push_back('{EV_LATCH, r, 0});
            exp_q.push_back('{EV_SHOW, t_show(p), r});
        end
        exp_q.push_back('{EV_DONE, s + plane_len(p), p});
    endtask

    task automatic sb_pop(input ev_kind_t k, input int a, input int b);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d a=%0d b=%0d, expected none (cycle %0d)",
                     int'(k), a, b, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            check("event_a", a, e.a);
            check("event_b", b, e.b);
        end
    endtask

    // Monitor: watches panel outputs on the falling edge and feeds the scoreboard.
    logic prev_sclk = 1'b0;
    int   oe_run    = 0;
    int   oe_row    = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_sclk = 1'b0;
            oe_run    = 0;
        end else begin
            if (bus.out_SHIFT_CLK && !prev_sclk) sb_pop(EV_SHIFT, int'(bus.out_COL), 0);
            if (bus.out_LATCH) sb_pop(EV_LATCH, int'(bus.out_ROW), 0);
            if (!bus.out_OE_N) begin
                oe_run++;
                oe_row = int'(bus.out_ROW);
            end else if (oe_run > 0) begin
                sb_pop(EV_SHOW, oe_run, oe_row);
                oe_run = 0;
            end
            if (bus.out_PLANE_DONE) sb_pop(EV_DONE, cyc, int'(bus.out_PLANE));
            if (bus.out_SHIFT_CLK || bus.out_LATCH) check("oe_invariant", int'(bus.out_OE_N), 1);
            prev_sclk = bus.out_SHIFT_CLK;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.out_BUSY && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(bus.out_BUSY), 0);
    endtask

    // Issue one start pulse (or hold it through a plane, which yields two back-to-back planes).
    task automatic run_plane(input bit hold, input int gap);
        int s, s2, p;
        repeat (gap) @(negedge clk);
        bus.in_HUB75_INIT = 1'b1;
        s = cyc + 1;
        p = model_plane;
        push_plane(p, s);
        model_plane = (model_plane + 1) % PLANES;
        if (hold) begin
            // DONE then one IDLE cycle, which samples the still-high start line.
            s2 = s + plane_len(p) + 2;
            push_plane(model_plane, s2);
            model_plane = (model_plane + 1) % PLANES;
            while (cyc < s2 + 2) @(negedge clk);
        end else begin
            @(negedge clk);
        end
        bus.in_HUB75_INIT = 1'b0;
        wait_idle();
        check("plane_after_done", int'(bus.out_PLANE), model_plane);
    endtask

    task automatic check_reset_state();
        check("rst_oe_n", int'(bus.out_OE_N), 1);
        check("rst_sclk", int'(bus.out_SHIFT_CLK), 0);
        check("rst_latch", int'(bus.out_LATCH), 0);
        check("rst_done", int'(bus.out_PLANE_DONE), 0);
        check("rst_busy", int'(bus.out_BUSY), 0);
        check("rst_col", int'(bus.out_COL), 0);
        check("rst_row", int'(bus.out_ROW), 0);
        check("rst_plane", int'(bus.out_PLANE), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_HUB75_INIT = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state();
        bus.in_HUB75_INIT = 1'b0;
        rst = 1'b0;

        run_plane(1'b0, 2);
        run_plane(1'b0, 0);

        // Reset in the middle of a row while SHIFT_CLK is high.
        bus.in_HUB75_INIT = 1'b1;
        push_plane(model_plane, cyc + 1);
        @(negedge clk);
        bus.in_HUB75_INIT = 1'b0;
        n = 0;
        while ((!bus.out_SHIFT_CLK || bus.out_COL != 2'd2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_shift_hi", int'(bus.out_SHIFT_CLK), 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        model_plane = 0;

        // Plane wrap: 1,2,3,0.
        for (int i = 0; i < PLANES; i++) run_plane(1'b0, $urandom_range(0, 3));

        for (int i = 0; i < 10; i++) run_plane(1'b1 & $urandom_range(0, 1), $urandom_range(0, 4));

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hub75_scan_ctrl.md
HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

Interface
REQ-001 SHALL have parameter COLS, 64, number of columns shifted per row.
REQ-002 SHALL have parameter ROWS, 16, number of row addresses per plane, with 1/ROWS scan.
REQ-003 SHALL have parameter PLANES, 8, number of bit-planes per frame.
REQ-004 SHALL have parameter DELAY_BASE, 16, cycles OE_N is held low for plane 0.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port in_HUB75_INIT  in  1  start-plane pulse from run_CACHE.
REQ-008 SHALL have port out_COL  out  clog2(COLS)  column address to the plane cache.
REQ-009 SHALL have port out_ROW  out  clog2(ROWS)  panel row address A..D.
REQ-010 SHALL have port out_PLANE  out  clog2(PLANES)  current bit-plane index.
REQ-011 SHALL have port out_SHIFT_CLK  out  1  panel CLK.
REQ-012 SHALL have port out_LATCH  out  1  panel LAT.
REQ-013 SHALL have port out_OE_N  out  1  panel OE, active low.
REQ-014 SHALL have port out_PLANE_DONE  out  1  one-cycle pulse when the plane is displayed; it drives run_CACHE in_INIT.
REQ-015 SHALL have port out_BUSY  out  1  high whenever the block is not in IDLE.

Function
REQ-016 SHALL implement the registered FSM IDLE, SHIFT_LO, SHIFT_HI, BLANK, LATCH, SHOW, DONE, with all outputs registered.
REQ-017 SHALL, in IDLE, hold OE_N=1, SHIFT_CLK=0, LATCH=0 and PLANE_DONE=0; in_HUB75_INIT=1 → SHIFT_LO, with col=0 and row=0.
REQ-018 SHALL, in SHIFT_LO, drive SHIFT_CLK=0 and out_COL=col for one cycle (cache data setup), then go to SHIFT_HI.
REQ-019 SHALL, in SHIFT_HI, drive SHIFT_CLK=1 for one cycle; if col==COLS-1 → BLANK, else col+1 → SHIFT_LO.
REQ-020 SHALL, in BLANK, force OE_N=1 for one cycle and load out_ROW with row.
REQ-021 SHALL, in LATCH, drive LATCH=1 for exactly one cycle, then go to SHOW.
REQ-022 SHALL, in SHOW, drive OE_N=0 for exactly T_show cycles; on expiry, if row==ROWS-1 → DONE, else row+1, col=0 → SHIFT_LO.
REQ-023 SHALL hold OE_N=1 in every state except SHOW.
REQ-024 SHALL, in DONE, pulse PLANE_DONE=1 for one cycle, advance plane (PLANES-1 wraps to 0), then go to IDLE.
REQ-025 SHALL produce 2*COLS+2+T_show cycles per row, and the first SHIFT_LO cycle on the edge after INIT is sampled.
REQ-026 SHALL ignore in_HUB75_INIT when not in IDLE (no restart, no queueing).
REQ-027 SHALL NOT sample in_HUB75_INIT in the DONE cycle; it is accepted from IDLE on the next cycle.
REQ-028 SHALL size the show counter to hold DELAY_BASE<<(PLANES-1) without overflow.

Reset
REQ-029 SHALL, when rst=1 at any edge including mid-row, set state=IDLE, col=row=plane=0, OE_N=1, and all other outputs 0.
REQ-030 SHALL give rst priority over in_HUB75_INIT in the same cycle.

Configuration
REQ-031 SHALL, with HUB75_BCM_EN defined, use T_show = DELAY_BASE << out_PLANE (binary-coded modulation).
REQ-032 SHALL, without HUB75_BCM_EN, use T_show = DELAY_BASE for every plane, with the plane counter still advancing.

Structure
REQ-033 SHALL place the state encoding typedef and the default COLS/ROWS/PLANES/DELAY_BASE constants in shared package hub75_pkg.
REQ-034 SHALL put the SHOW-duration counter in sub-module hub75_show_timer (load, count, done).

Verification (COLS=4, ROWS=2, PLANES=4, DELAY_BASE=3)
REQ-035 SHALL cover reset: rst=1 mid-SHIFT_HI → next cycle OE_N=1, SHIFT_CLK=0, BUSY=0, COL=ROW=PLANE=0.
REQ-036 SHALL cover one plane: INIT pulse at plane 0 → 4 SHIFT_CLK rising edges with COL 0..3, LAT pulse, OE_N low 3 cycles, per row; PLANE_DONE exactly 26 cycles after INIT sampled.
REQ-037 SHALL cover BCM with HUB75_BCM_EN: at PLANE=2 → OE_N low 12 cycles per row; without the macro → 3 cycles.
REQ-038 SHALL cover plane wrap: four INIT/DONE cycles → PLANE reads 1,2,3,0 after each DONE.
REQ-039 SHALL cover INIT while busy: INIT held high for the whole plane → exactly one PLANE_DONE before IDLE, then a new plane starts the following cycle.
REQ-040 SHALL cover the OE invariant: assert OE_N==1 whenever SHIFT_CLK or LATCH is 1, across all scenarios.
